// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine for the HI/LO path; {hi,lo} loaded on a one-cycle done pulse.
// Latency WIDTH+1 cycles from accept to done (multiply 1 cycle when MULDIV_FAST_MUL_EN is defined).
// Backpressure: busy stalls EX; start is dropped while busy; flush cancels with no done.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] ph;
    logic [WIDTH-1:0] pl;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   ph_nxt;
    logic [WIDTH-1:0]   pl_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               dz;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

    // Signed ops work on magnitudes; -2^(W-1) maps onto itself, which is its correct unsigned magnitude.
    always_comb begin
        abs_a = (!op[0] && a[WIDTH-1]) ? -a : a;
        abs_b = (!op[0] && b[WIDTH-1]) ? -b : b;
    end

    // One radix-2 step. Multiply: {ph,pl} shifts right with pl holding the multiplier.
    // Divide: pl holds the dividend shifting out MSB-first while quotient bits shift in.
    always_comb begin
        addend  = pl[0] ? dsr : {WIDTH{1'b0}};
        add_sum = {1'b0, ph} + {1'b0, addend};
        shifted = {ph, pl[WIDTH-1]};
        diff    = shifted - {1'b0, dsr};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                ph_nxt = diff[WIDTH-1:0];
                pl_nxt = {pl[WIDTH-2:0], 1'b1};
            end else begin
                ph_nxt = shifted[WIDTH-1:0];
                pl_nxt = {pl[WIDTH-2:0], 1'b0};
            end
        end else begin
            ph_nxt = add_sum[WIDTH:1];
            pl_nxt = {add_sum[0], pl[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = {ph, pl};
        dz   = is_div && (dsr == {WIDTH{1'b0}});
        if (!is_div) begin
            {res_hi, res_lo} = neg_q ? -prod : prod;
        end else if (dz) begin
            res_hi = a_r;
            res_lo = {WIDTH{1'b1}};
        end else begin
            res_lo = neg_q ? -pl : pl;
            res_hi = neg_r ? -ph : ph;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            a_r      <= '0;
            dsr      <= '0;
            ph       <= '0;
            pl       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        is_div   <= op[1];
                        neg_q    <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= !op[0] && a[WIDTH-1];
                        a_r      <= a;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        ph       <= '0;
                        dsr      <= op[1] ? abs_b : abs_a;
                        pl       <= op[1] ? abs_a : abs_b;
                        state    <= RUN;
`ifdef MULDIV_FAST_MUL_EN
                        if (!op[1]) begin
                            {ph, pl} <= fast_prod;
                            state    <= FINISH;
                        end
`endif
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ph  <= ph_nxt;
                        pl  <= pl_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1))
                            state <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi       <= res_hi;
                        lo       <= res_lo;
                        div_zero <= dz;
                        done     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expectations queued at accept, checked when done pulses.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic signed [63:0] sx, sy, q, m;
        logic [63:0] r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        e.dz = 1'b0;
        e.acc = 0;
        r = '0;
        case (o)
            2'd0: r = sx * sy;
            2'd1: r = {32'b0, x} * {32'b0, y};
            2'd2: begin
                if (y == 0) begin
                    r = {x, 32'hFFFF_FFFF};
                    e.dz = 1'b1;
                end else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) begin
                    r = {x, 32'hFFFF_FFFF};
                    e.dz = 1'b1;
                end else begin
                    r = {x % y, x / y};
                end
            end
        endcase
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.lat = o[1] ? 33 : MUL_LAT;
        return e;
    endfunction

    // Output monitor: every done must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", {63'b0, done}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("hi", {32'b0, hi}, {32'b0, e.hi});
                    check("lo", {32'b0, lo}, {32'b0, e.lo});
                    check("div_zero", {63'b0, div_zero}, {63'b0, e.dz});
                    check("latency", 64'(cyc - e.acc), 64'(e.lat));
                    check("busy_at_done", {63'b0, busy}, 64'd0);
                    last_hi = e.hi;
                    last_lo = e.lo;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("busy_timeout", {63'b0, busy}, 64'd0);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = model(o, x, y);
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {63'b0, busy}, 64'd0);
        check({tag, "_done"}, {63'b0, done}, 64'd0);
        check({tag, "_hi"}, {32'b0, hi}, 64'd0);
        check({tag, "_lo"}, {32'b0, lo}, 64'd0);
        check({tag, "_dz"}, {63'b0, div_zero}, 64'd0);
    endtask

    initial begin
        exp_t e;
        int n;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
        issue(2'd0, 32'hFFFF_FFF9, 32'd3);         wait_idle();
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);         wait_idle();
        issue(2'd3, 32'd100, 32'd7);               wait_idle();
        issue(2'd3, 32'd5, 32'd0);                 wait_idle();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        issue(2'd2, 32'hFFFF_FFF0, 32'd0);         wait_idle();
        issue(2'd2, 32'd7, 32'hFFFF_FFFE);         wait_idle();
        issue(2'd0, 32'h8000_0000, 32'h8000_0000); wait_idle();
        issue(2'd0, 32'h7FFF_FFFF, 32'h8000_0000); wait_idle();
        for (int i = 0; i < 16; i++) begin
            issue(2'($urandom_range(0, 3)), $urandom(),
                  (i % 5 == 4) ? 32'd0 : (32'($urandom) >> $urandom_range(0, 31)));
            wait_idle();
        end

        // Back-to-back: second start driven in the done cycle.
        issue(2'd3, 32'd1000, 32'd7);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 100);
        start = 1'b1; op = 2'd2; a = 32'hFFFF_FC18; b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = model(2'd2, 32'hFFFF_FC18, 32'd9);
        e.acc = cyc;
        sb.push_back(e);
        check("b2b_busy", {63'b0, busy}, 64'd1);
        wait_idle();

        // start while busy is dropped.
        issue(2'd3, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ignored_start_busy", {63'b0, busy}, 64'd1);
        wait_idle();
        repeat (40) @(negedge clk);

        // Flush mid-divide: no done, hi/lo untouched.
        issue(2'd2, 32'hFFFF_FF9C, 32'd7);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_hi_kept", {32'b0, hi}, {32'b0, last_hi});
        check("flush_lo_kept", {32'b0, lo}, {32'b0, last_lo});

        // flush and start together: not accepted.
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 2'd3; a = 32'd50; b = 32'd5;
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        check("flush_start_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);

        // Reset mid-operation.
        issue(2'd0, 32'd123, 32'd456);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(2'd3, 32'd100, 32'd7); wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
